mix_columns_engine: RTL and testbench

Parametrised, iterative AES (Inv)MixColumns unit for the AES-256 datapath. It accepts a full state word over a valid/ready handshake and processes one 32-bit column per clock through a single shared column datapath. A per-transaction mode bit selects forward MixColumns (encryption) or InvMixColumns (decryption), and a bypass bit passes the state through unchanged for the final round. The round controller of both the encryption and decryption cores instantiates this block in place of per-column combinational helpers.

---
 rtl/mix_columns_engine.sv | 157 +++++++++++++++
 tb/tb_mix_columns_engine.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mix_columns_engine.sv
// Iterative AES (Inv)MixColumns engine: one 32-bit column per clock through a
// shared column datapath, with per-transaction mode and bypass.
module mix_columns_engine #(
    parameter int NUM_COLS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [32*NUM_COLS-1:0]  in_data,
    input  logic                    in_inv,
    input  logic                    in_bypass,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [32*NUM_COLS-1:0]  out_data,
    output logic                    busy
);

    localparam int W  = 32 * NUM_COLS;
    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  data_q;
    logic          inv_q;
    logic [CW-1:0] col_idx;
    logic [31:0]   col_in;
    logic [31:0]   col_out;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return xt(b);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xt(b) ^ b;
    endfunction

    // 9, B, D, E are sums of x8, x4, x2 and x1 of the operand.
    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    function automatic logic [31:0] fwd_mix(input logic [31:0] col);
        logic [7:0] a, b, c, d;
        {a, b, c, d} = col;
        return {mul2(a) ^ mul3(b) ^ c       ^ d,
                a       ^ mul2(b) ^ mul3(c) ^ d,
                a       ^ b       ^ mul2(c) ^ mul3(d),
                mul3(a) ^ b       ^ c       ^ mul2(d)};
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] col);
        logic [7:0] a, b, c, d;
        {a, b, c, d} = col;
        return {mule(a) ^ mulb(b) ^ muld(c) ^ mul9(d),
                mul9(a) ^ mule(b) ^ mulb(c) ^ muld(d),
                muld(a) ^ mul9(b) ^ mule(c) ^ mulb(d),
                mulb(a) ^ muld(b) ^ mul9(c) ^ mule(d)};
    endfunction

    // Column 0 sits in the most significant word of the state.
    always_comb begin
        col_in = '0;
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            if (col_idx == CW'(i)) begin
                col_in = data_q[32*(NUM_COLS-1-i) +: 32];
            end
        end
    end

    always_comb begin
        col_out = inv_q ? inv_mix(col_in) : fwd_mix(col_in);
    end

    // in_ready is a registered flag so it stays low during reset and rises one
    // edge after reset release or after the output handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            data_q    <= '0;
            inv_q     <= 1'b0;
            col_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready && in_valid) begin
                        data_q   <= in_data;
                        inv_q    <= in_inv;
                        col_idx  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_bypass) begin
                            out_data  <= in_data;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                BUSY: begin
                    for (int unsigned i = 0; i < NUM_COLS; i++) begin
                        if (col_idx == CW'(i)) begin
                            out_data[32*(NUM_COLS-1-i) +: 32] <= col_out;
                        end
                    end
                    if (col_idx == LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        col_idx <= col_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine with NUM_COLS = 4, 1 and 8 instances.
module tb_mix_columns_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic         in_valid4 = 1'b0, in_inv4 = 1'b0, in_bypass4 = 1'b0, out_ready4 = 1'b0;
    logic         in_ready4, out_valid4, busy4;
    logic [127:0] in_data4 = '0;
    logic [127:0] out_data4;

    logic         in_valid1 = 1'b0, in_inv1 = 1'b0, in_bypass1 = 1'b0, out_ready1 = 1'b1;
    logic         in_ready1, out_valid1, busy1;
    logic [31:0]  in_data1 = '0;
    logic [31:0]  out_data1;

    logic         in_valid8 = 1'b0, in_inv8 = 1'b0, in_bypass8 = 1'b0, out_ready8 = 1'b1;
    logic         in_ready8, out_valid8, busy8;
    logic [255:0] in_data8 = '0;
    logic [255:0] out_data8;

    mix_columns_engine #(.NUM_COLS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data4), .in_inv(in_inv4), .in_bypass(in_bypass4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .busy(busy4)
    );

    mix_columns_engine #(.NUM_COLS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .in_inv(in_inv1), .in_bypass(in_bypass1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .busy(busy1)
    );

    mix_columns_engine #(.NUM_COLS(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .in_inv(in_inv8), .in_bypass(in_bypass8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    localparam logic [127:0] BYP     = 128'h00112233_44556677_8899aabb_ccddeeff;

    int cyc;
    int seen;

    initial begin
        // reset state
        tick();
        tick();
        check("rst_in_ready", in_ready4, 0);
        check("rst_out_valid", out_valid4, 0);
        check("rst_busy", busy4, 0);
        check("rst_out_data", out_data4, 0);
        rst_n = 1'b1;
        tick();
        check("rdy_after_rst", in_ready4, 1);

        // forward with latency
        in_valid4 = 1'b1; in_data4 = FWD_IN; in_inv4 = 1'b0; in_bypass4 = 1'b0; out_ready4 = 1'b0;
        tick();
        in_valid4 = 1'b0;
        check("fwd_busy", busy4, 1);
        check("fwd_not_ready", in_ready4, 0);
        cyc = 0;
        while (!out_valid4 && cyc < 20) begin tick(); cyc++; end
        check("fwd_latency", cyc, 4);
        check("fwd_data", out_data4, FWD_OUT);

        // backpressure with a pending second transaction
        in_valid4 = 1'b1; in_data4 = INV_IN; in_inv4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_data", out_data4, FWD_OUT);
            check("bp_valid", out_valid4, 1);
            check("bp_ready", in_ready4, 0);
        end
        out_ready4 = 1'b1;
        tick();
        check("bp_ready_rise", in_ready4, 1);
        check("bp_valid_drop", out_valid4, 0);
        tick();
        in_valid4 = 1'b0;
        check("inv_accept_busy", busy4, 1);
        cyc = 0;
        while (!out_valid4 && cyc < 20) begin tick(); cyc++; end
        check("inv_latency", cyc, 4);
        check("inv_data", out_data4, INV_OUT);

        // bypass
        cyc = 0;
        while (!in_ready4 && cyc < 20) begin tick(); cyc++; end
        check("byp_ready", in_ready4, 1);
        in_valid4 = 1'b1; in_data4 = BYP; in_inv4 = 1'b0; in_bypass4 = 1'b1;
        tick();
        in_valid4 = 1'b0; in_bypass4 = 1'b0; in_data4 = '0;
        check("byp_latency1", out_valid4, 1);
        check("byp_data", out_data4, BYP);
        tick();
        check("byp_done", out_valid4, 0);

        // reset in the middle of BUSY
        cyc = 0;
        while (!in_ready4 && cyc < 20) begin tick(); cyc++; end
        in_valid4 = 1'b1; in_data4 = FWD_IN; in_inv4 = 1'b0;
        tick();
        in_valid4 = 1'b0;
        tick();
        tick();
        check("mid_busy", busy4, 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", out_valid4, 0);
        check("mid_rst_data", out_data4, 0);
        check("mid_rst_busy", busy4, 0);
        check("mid_rst_ready", in_ready4, 0);
        rst_n = 1'b1;
        tick();
        check("mid_ready_back", in_ready4, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid4) seen++;
        end
        check("mid_no_stale", seen, 0);

        // NUM_COLS = 1
        in_valid1 = 1'b1; in_data1 = 32'hdb135345; in_inv1 = 1'b0;
        tick();
        in_valid1 = 1'b0;
        cyc = 0;
        while (!out_valid1 && cyc < 20) begin tick(); cyc++; end
        check("n1_latency", cyc, 1);
        check("n1_data", out_data1, 32'h8e4da1bc);

        // NUM_COLS = 8
        in_valid8 = 1'b1; in_data8 = {8{32'h9fdc589d}}; in_inv8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        cyc = 0;
        while (!out_valid8 && cyc < 30) begin tick(); cyc++; end
        check("n8_latency", cyc, 8);
        check("n8_data", out_data8, {8{32'hf20a225c}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
